// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - IF/ID front-end sequencing: load-use / HI-LO / imem stalls, branches, exception drain
module pipe_hazard_ctrl #(
    parameter int MULDIV_LAT = 32,
    parameter int EXC_DRAIN  = 2,
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_mfhilo,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_muldiv_start,
    input  logic             br,
    input  logic             except,
    input  logic             imem_ready,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             epc_capture,
    output logic             muldiv_busy,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int MD_W = $clog2(MULDIV_LAT + 1);
    localparam int DR_W = (EXC_DRAIN > 1) ? $clog2(EXC_DRAIN) : 1;

    typedef enum logic {RUN, EXC} state_t;

    state_t            state, state_nxt;
    logic [DR_W-1:0]   drain, drain_nxt;
    logic [MD_W-1:0]   md_cnt;
    logic              load_use;
    logic              hilo_stall;
    logic              stall_inc;

    assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                      ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
    assign hilo_stall  = id_is_mfhilo && ((md_cnt != '0) || ex_muldiv_start);
    assign muldiv_busy = (md_cnt != '0);

    // Outputs are forced low while rst is held so no strobe leaks during reset.
    always_comb begin
        state_nxt   = state;
        drain_nxt   = drain;
        pc_en       = 1'b0;
        pc_sel      = 2'd0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        epc_capture = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (except) begin
                        pc_sel      = 2'd2;
                        pc_en       = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        epc_capture = 1'b1;
                        state_nxt   = EXC;
                        drain_nxt   = DR_W'(EXC_DRAIN - 1);
                    end else if (!imem_ready || load_use || hilo_stall) begin
                        idex_bubble = 1'b1;
                    end else if (br) begin
                        pc_sel     = 2'd1;
                        pc_en      = 1'b1;
                        ifid_en    = 1'b1;
                        ifid_flush = (DELAY_SLOT == 0);
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                end
                EXC: begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (drain == '0) state_nxt = RUN;
                    else             drain_nxt = drain - DR_W'(1);
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    assign stall_inc = (state == RUN) && !pc_en && !except && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RUN;
            drain        <= '0;
            md_cnt       <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            drain <= drain_nxt;
            if (ex_muldiv_start)    md_cnt <= MD_W'(MULDIV_LAT);
            else if (md_cnt != '0)  md_cnt <= md_cnt - MD_W'(1);
            if (stall_inc && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed + random checks of pipe_hazard_ctrl against a cycle model
module tb_pipe_hazard_ctrl;
    localparam int LAT   = 4;
    localparam int DRAIN = 2;
    localparam int CW    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rt = '0;
    logic id_use_rs = 0, id_use_rt = 0, id_is_mfhilo = 0, ex_mem_read = 0;
    logic ex_muldiv_start = 0, br = 0, except = 0, imem_ready = 0;

    logic          a_pc_en, a_ifid_en, a_ifid_flush, a_idex_bubble, a_epc, a_busy;
    logic [1:0]    a_pc_sel;
    logic [CW-1:0] a_stall;
    logic          b_pc_en, b_ifid_en, b_ifid_flush, b_idex_bubble, b_epc, b_busy;
    logic [1:0]    b_pc_sel;
    logic [CW-1:0] b_stall;

    int n_tests = 0;
    int n_fail  = 0;

    int m_exc   = 0;
    int m_md    = 0;
    int m_stall = 0;
    logic [13:0] obs_a, obs_b;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MULDIV_LAT(LAT), .EXC_DRAIN(DRAIN), .DELAY_SLOT(0), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_is_mfhilo(id_is_mfhilo), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .ex_muldiv_start(ex_muldiv_start), .br(br), .except(except),
        .imem_ready(imem_ready), .pc_en(a_pc_en), .pc_sel(a_pc_sel), .ifid_en(a_ifid_en),
        .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble), .epc_capture(a_epc),
        .muldiv_busy(a_busy), .stall_cycles(a_stall));

    pipe_hazard_ctrl #(.MULDIV_LAT(LAT), .EXC_DRAIN(DRAIN), .DELAY_SLOT(1), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
        .id_use_rt(id_use_rt), .id_is_mfhilo(id_is_mfhilo), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .ex_muldiv_start(ex_muldiv_start), .br(br), .except(except),
        .imem_ready(imem_ready), .pc_en(b_pc_en), .pc_sel(b_pc_sel), .ifid_en(b_ifid_en),
        .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .epc_capture(b_epc),
        .muldiv_busy(b_busy), .stall_cycles(b_stall));

    function automatic logic [13:0] pack(logic pe, logic [1:0] ps, logic ie, logic fl,
                                         logic bu, logic ep, logic mb, logic [CW-1:0] sc);
        return {pe, ps, ie, fl, bu, ep, mb, sc};
    endfunction

    // Expected outputs for the current model state and inputs.
    function automatic logic [13:0] model_out(int ds);
        logic pe, ie, fl, bu, ep;
        logic [1:0] ps;
        logic lu, hs;
        pe = 0; ie = 0; fl = 0; bu = 0; ep = 0; ps = 0;
        lu = ex_mem_read && ex_rt != 0 &&
             ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
        hs = id_is_mfhilo && (m_md != 0 || ex_muldiv_start);
        if (rst) return '0;
        if (m_exc > 0) begin
            fl = 1; bu = 1;
        end else if (except) begin
            ps = 2; pe = 1; fl = 1; bu = 1; ep = 1;
        end else if (!imem_ready || lu || hs) begin
            bu = 1;
        end else if (br) begin
            ps = 1; pe = 1; ie = 1; fl = (ds == 0);
        end else begin
            pe = 1; ie = 1;
        end
        return pack(pe, ps, ie, fl, bu, ep, m_md != 0, CW'(m_stall));
    endfunction

    task automatic chk(input string tag, input logic [13:0] o, input logic [13:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic model_tick();
        logic [13:0] e;
        e = model_out(0);
        if (rst) begin
            m_exc = 0; m_md = 0; m_stall = 0;
        end else begin
            if (m_exc == 0 && !except && !e[13] && m_stall < (1 << CW) - 1) m_stall++;
            if (m_exc > 0) m_exc--;
            else if (except) m_exc = DRAIN;
            if (ex_muldiv_start) m_md = LAT;
            else if (m_md > 0) m_md--;
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        obs_a = pack(a_pc_en, a_pc_sel, a_ifid_en, a_ifid_flush, a_idex_bubble, a_epc, a_busy, a_stall);
        obs_b = pack(b_pc_en, b_pc_sel, b_ifid_en, b_ifid_flush, b_idex_bubble, b_epc, b_busy, b_stall);
        chk({tag, "_ds0"}, obs_a, model_out(0));
        chk({tag, "_ds1"}, obs_b, model_out(1));
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic idle();
        id_rs = 0; id_rt = 0; ex_rt = 0; id_use_rs = 0; id_use_rt = 0; id_is_mfhilo = 0;
        ex_mem_read = 0; ex_muldiv_start = 0; br = 0; except = 0; imem_ready = 1;
    endtask

    initial begin
        int s0;
        #1;
        chk("reset_state", pack(a_pc_en, a_pc_sel, a_ifid_en, a_ifid_flush, a_idex_bubble,
                                a_epc, a_busy, a_stall), '0);
        idle();
        step("in_reset");
        rst = 0;
        for (int i = 0; i < 4; i++) step("clean");
        chk("clean_stall0", {8'd0, obs_a[5:0]}, 14'd0);

        ex_mem_read = 1; ex_rt = 8; id_rs = 8; id_use_rs = 1;
        step("load_use");
        chk("lu_bubble", {12'd0, obs_a[13], obs_a[8]}, 14'b01);
        idle();
        step("after_lu");
        chk("lu_count", {8'd0, obs_a[5:0]}, 14'd1);

        s0 = m_stall;
        id_is_mfhilo = 1; ex_muldiv_start = 1;
        step("md_start");
        ex_muldiv_start = 0;
        for (int i = 0; i < 5; i++) step("md_wait");
        chk("md_released", {13'd0, obs_a[13]}, 14'd1);
        chk("md_stall5", 14'(m_stall - s0), 14'd5);
        idle();

        except = 1; br = 1; ex_mem_read = 1; ex_rt = 3; id_rt = 3; id_use_rt = 1;
        step("exc");
        chk("exc_sel_epc", {11'd0, obs_a[12:11], obs_a[7]}, 14'b101);
        step("exc_drain1");
        except = 0;
        step("exc_drain2");
        chk("drain_no_epc", {13'd0, obs_a[7]}, 14'd0);
        idle();
        step("exc_exit");

        br = 1;
        step("branch");
        chk("br_flush_ds0_ds1", {10'd0, obs_a[12:11], obs_a[9], obs_b[9]}, 14'b0110);
        idle();

        ex_muldiv_start = 1; except = 1;
        step("pre_rst_a");
        idle();
        step("pre_rst_b");
        rst = 1;
        #1;
        chk("rst_async", pack(a_pc_en, a_pc_sel, a_ifid_en, a_ifid_flush, a_idex_bubble,
                              a_epc, a_busy, a_stall), '0);
        m_exc = 0; m_md = 0; m_stall = 0;
        step("rst_hold");
        rst = 0;
        step("rst_released");
        chk("rst_run", {12'd0, obs_a[13], obs_a[6]}, 14'b10);

        for (int i = 0; i < 400; i++) begin
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            id_use_rs       = 1'($urandom_range(0, 1));
            id_use_rt       = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            id_is_mfhilo    = ($urandom_range(0, 3) == 0);
            ex_muldiv_start = ($urandom_range(0, 15) == 0);
            br              = ($urandom_range(0, 2) == 0);
            except          = ($urandom_range(0, 19) == 0);
            imem_ready      = ($urandom_range(0, 7) != 0);
            step("rand");
        end

        idle();
        imem_ready = 0;
        for (int i = 0; i < 70; i++) step("sat");
        chk("stall_saturated", {8'd0, obs_a[5:0]}, {8'd0, {CW{1'b1}}});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
